// File: rtl/uart_relay_ctrl_if.sv
// rtl/uart_relay_ctrl_if.sv - received-byte strobe bundle between uart_rx and the relay controller.
interface uart_relay_ctrl_if;
   logic [7:0] rx_byte;
   logic       rx_valid;

   modport master (output rx_byte, output rx_valid);
   modport slave  (input  rx_byte, input  rx_valid);
endinterface

// File: rtl/uart_relay_ctrl.sv
// rtl/uart_relay_ctrl.sv - single-byte command decoder driving the relay bank and RGB status LED,
// with a legacy three-state cycle mode selected by MODE_CYCLE.
module uart_relay_ctrl #(
   parameter int N_RELAY      = 4,
   parameter int PULSE_CYCLES = 12_000_000,
   parameter bit ACTIVE_LOW   = 1'b1,
   parameter bit MODE_CYCLE   = 1'b0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   uart_relay_ctrl_if.slave    rx,
   output logic [N_RELAY-1:0]  relay_o,
   output logic [2:0]          rgb_o,
   output logic                cmd_err_o,
   output logic                pulse_active_o
);

   logic [N_RELAY-1:0] relay_on_q;
   logic [2:0]         rgb_q;
   logic               cmd_err_q;
   logic               pulse_active_q;

   assign relay_o        = ACTIVE_LOW ? ~relay_on_q : relay_on_q;
   assign rgb_o          = rgb_q;
   assign cmd_err_o      = cmd_err_q;
   assign pulse_active_o = pulse_active_q;

   if (MODE_CYCLE) begin : g_cycle
      typedef enum logic [1:0] {
         S0    = 2'b00,
         S1    = 2'b01,
         S2    = 2'b10,
         S_ILL = 2'b11
      } cyc_state_e;

      cyc_state_e state_q;
      logic       unused_byte;

      // Byte contents are irrelevant here; only the strobe advances the cycle.
      assign unused_byte = ^rx.rx_byte;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state_q        <= S0;
            relay_on_q     <= '0;
            rgb_q          <= 3'b001;
            cmd_err_q      <= 1'b0;
            pulse_active_q <= 1'b0;
         end else begin
            cmd_err_q      <= 1'b0;
            pulse_active_q <= 1'b0;
            if (state_q == S_ILL) begin
               state_q    <= S0;
               rgb_q      <= 3'b001;
               relay_on_q <= '0;
            end else if (rx.rx_valid) begin
               relay_on_q <= '0;
               case (state_q)
                  S0: begin
                     state_q       <= S1;
                     rgb_q         <= 3'b001;
                     relay_on_q[0] <= 1'b1;
                  end
                  S1: begin
                     state_q <= S2;
                     rgb_q   <= 3'b010;
                  end
                  default: begin
                     state_q <= S0;
                     rgb_q   <= 3'b100;
                  end
               endcase
            end
         end
      end
   end else begin : g_cmd
      localparam int TW = $clog2(PULSE_CYCLES + 1);
      localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES);

      logic [TW-1:0]      timer_q [N_RELAY];
      logic [TW-1:0]      timer_d [N_RELAY];
      logic [N_RELAY-1:0] expire_q;
      logic [N_RELAY-1:0] expire_d;
      logic [N_RELAY-1:0] relay_on_d;
      logic [N_RELAY-1:0] busy;
      logic [N_RELAY-1:0] ch_sel;
      logic [2:0]         rgb_d;
      logic               cmd_err_d;
      logic               pulse_active_d;
      logic [1:0]         op;
      logic [4:0]         ch;
      logic               ch_ok;

      assign op    = rx.rx_byte[7:6];
      assign ch    = rx.rx_byte[4:0];
      assign ch_ok = (int'(ch) < N_RELAY);

      // expire_q marks the cycle after a timer reached zero; the relay drops one
      // edge later so the on-window spans PULSE_CYCLES+1 cycles.
      always_comb begin
         relay_on_d = relay_on_q;
         rgb_d      = rgb_q;
         cmd_err_d  = 1'b0;
         for (int i = 0; i < N_RELAY; i++) begin
            ch_sel[i]   = (int'(ch) == i);
            busy[i]     = (timer_q[i] != '0);
            timer_d[i]  = busy[i] ? timer_q[i] - 1'b1 : timer_q[i];
            expire_d[i] = (timer_q[i] == TW'(1));
            if (expire_q[i]) begin
               relay_on_d[i] = 1'b0;
            end
         end
         pulse_active_d = (|busy) | (|expire_q);

         if (rx.rx_valid) begin
            if (op == 2'b11) begin
               if (rx.rx_byte[5]) begin
                  relay_on_d = '0;
                  expire_d   = '0;
                  for (int i = 0; i < N_RELAY; i++) begin
                     timer_d[i] = '0;
                  end
               end else begin
                  rgb_d = rx.rx_byte[2:0];
               end
            end else if (!ch_ok) begin
               cmd_err_d = 1'b1;
            end else begin
               // A channel command overrides any expiry landing on the same edge.
               for (int i = 0; i < N_RELAY; i++) begin
                  if (ch_sel[i]) begin
                     expire_d[i] = 1'b0;
                     case (op)
                        2'b00: begin
                           relay_on_d[i] = rx.rx_byte[5];
                           timer_d[i]    = '0;
                        end
                        2'b01: begin
                           relay_on_d[i] = ~relay_on_q[i];
                           timer_d[i]    = '0;
                        end
                        default: begin
                           relay_on_d[i] = 1'b1;
                           timer_d[i]    = PULSE_LOAD;
                        end
                     endcase
                  end
               end
            end
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            relay_on_q     <= '0;
            rgb_q          <= 3'b001;
            cmd_err_q      <= 1'b0;
            pulse_active_q <= 1'b0;
            expire_q       <= '0;
            for (int i = 0; i < N_RELAY; i++) begin
               timer_q[i] <= '0;
            end
         end else begin
            relay_on_q     <= relay_on_d;
            rgb_q          <= rgb_d;
            cmd_err_q      <= cmd_err_d;
            pulse_active_q <= pulse_active_d;
            expire_q       <= expire_d;
            for (int i = 0; i < N_RELAY; i++) begin
               timer_q[i] <= timer_d[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_relay_ctrl.sv
// tb/tb_uart_relay_ctrl.sv - self-checking bench for uart_relay_ctrl in command and cycle modes.
module tb_uart_relay_ctrl;
   localparam int P = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] relay_c;
   logic [2:0] rgb_c;
   logic       err_c;
   logic       pa_c;
   logic [2:0] relay_y;
   logic [2:0] rgb_y;
   logic       err_y;
   logic       pa_y;

   int checks = 0;
   int errors = 0;

   logic [3:0] m_on;
   bit         m_puls [4];
   int         m_dead [4];
   logic [2:0] m_rgb;
   logic       m_err;
   logic       m_pa;
   int         m_bytes;
   int         cyc = 0;

   uart_relay_ctrl_if rx_if ();

   always #5 clk = ~clk;

   uart_relay_ctrl #(.N_RELAY(4), .PULSE_CYCLES(P), .ACTIVE_LOW(1), .MODE_CYCLE(0)) dut_cmd (
      .clk_i(clk), .rst_i(rst), .rx(rx_if),
      .relay_o(relay_c), .rgb_o(rgb_c), .cmd_err_o(err_c), .pulse_active_o(pa_c));

   uart_relay_ctrl #(.N_RELAY(3), .PULSE_CYCLES(P), .ACTIVE_LOW(0), .MODE_CYCLE(1)) dut_cyc (
      .clk_i(clk), .rst_i(rst), .rx(rx_if),
      .relay_o(relay_y), .rgb_o(rgb_y), .cmd_err_o(err_y), .pulse_active_o(pa_y));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock edge: drive inputs, advance the reference model, then compare both DUTs.
   task automatic step(input logic v, input logic [7:0] b, input logic r = 1'b0);
      logic [3:0] old_on;
      logic [3:0] exp_relay;
      logic [2:0] exp_cyc_relay;
      logic [2:0] exp_cyc_rgb;
      bit         any_puls;
      int         ch;
      rx_if.rx_valid = v;
      rx_if.rx_byte  = b;
      rst            = r;
      @(posedge clk);
      cyc++;
      if (r) begin
         m_on = '0; m_rgb = 3'b001; m_err = 1'b0; m_pa = 1'b0; m_bytes = 0;
         for (int i = 0; i < 4; i++) m_puls[i] = 0;
      end else begin
         any_puls = 0;
         for (int i = 0; i < 4; i++) any_puls |= m_puls[i];
         old_on = m_on;
         for (int i = 0; i < 4; i++) begin
            if (m_puls[i] && m_dead[i] == cyc) begin
               m_on[i] = 1'b0;
               m_puls[i] = 0;
            end
         end
         m_err = 1'b0;
         if (v) begin
            m_bytes++;
            ch = int'(b[4:0]);
            if (b[7:6] == 2'b11) begin
               if (b[5]) begin
                  m_on = '0;
                  for (int i = 0; i < 4; i++) m_puls[i] = 0;
               end else begin
                  m_rgb = b[2:0];
               end
            end else if (ch >= 4) begin
               m_err = 1'b1;
            end else if (b[7:6] == 2'b00) begin
               m_on[ch] = b[5]; m_puls[ch] = 0;
            end else if (b[7:6] == 2'b01) begin
               m_on[ch] = ~old_on[ch]; m_puls[ch] = 0;
            end else begin
               m_on[ch] = 1'b1; m_puls[ch] = 1; m_dead[ch] = cyc + P + 1;
            end
         end
         m_pa = any_puls;
      end
      #1;
      exp_relay = ~m_on;
      chk("relay", relay_c, exp_relay);
      chk("rgb", rgb_c, m_rgb);
      chk("cmd_err", err_c, m_err);
      chk("pulse_active", pa_c, m_pa);
      exp_cyc_relay = {2'b00, (m_bytes % 3 == 1)};
      if (m_bytes == 0 || m_bytes % 3 == 1) exp_cyc_rgb = 3'b001;
      else if (m_bytes % 3 == 2)            exp_cyc_rgb = 3'b010;
      else                                  exp_cyc_rgb = 3'b100;
      chk("cyc_relay", relay_y, exp_cyc_relay);
      chk("cyc_rgb", rgb_y, exp_cyc_rgb);
      chk("cyc_err_pa", {err_y, pa_y}, 2'b00);
   endtask

   initial begin
      int         low_cnt;
      logic [7:0] b;
      int         kind;
      rx_if.rx_valid = 1'b0;
      rx_if.rx_byte  = 8'h00;

      step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h22, 1'b1);
      chk("reset_relay", relay_c, 4'b1111);
      chk("reset_rgb", rgb_c, 3'b001);
      chk("reset_err_pa", {err_c, pa_c}, 2'b00);

      step(1'b1, 8'h22); chk("set_ch2", relay_c, 4'b1011);
      step(1'b1, 8'h42); chk("toggle_ch2", relay_c, 4'b1111);
      step(1'b1, 8'hC6); chk("rgb_cmd", rgb_c, 3'b110);
      step(1'b0, 8'h81); chk("invalid_ignored", relay_c, 4'b1111);

      step(1'b1, 8'h81);
      low_cnt = (relay_c[1] == 1'b0) ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 8'h00);
         if (relay_c[1] == 1'b0) low_cnt++;
      end
      chk("pulse_width", low_cnt, 11);

      step(1'b1, 8'h81);
      low_cnt = 1;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 8'h00);
         if (relay_c[1] == 1'b0) low_cnt++;
      end
      step(1'b1, 8'h81);
      if (relay_c[1] == 1'b0) low_cnt++;
      for (int i = 0; i < 25; i++) begin
         step(1'b0, 8'h00);
         if (relay_c[1] == 1'b0) low_cnt++;
      end
      chk("pulse_restart_width", low_cnt, 16);

      step(1'b1, 8'h81);
      for (int i = 0; i < P; i++) step(1'b0, 8'h00);
      step(1'b1, 8'h21);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
      chk("set_on_expiry", relay_c, 4'b1101);

      step(1'b1, 8'h07);
      chk("bad_ch_err", err_c, 1'b1);
      chk("bad_ch_relay", relay_c, 4'b1101);
      step(1'b0, 8'h00);
      chk("bad_ch_err_clear", err_c, 1'b0);

      step(1'b1, 8'h80);
      step(1'b1, 8'h83);
      step(1'b1, 8'hE0);
      chk("alloff_relay", relay_c, 4'b1111);
      step(1'b0, 8'h00);
      chk("alloff_pa", pa_c, 1'b0);

      step(1'b1, 8'h80);
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
      step(1'b1, 8'h21, 1'b1);
      chk("rst_mid_relay", relay_c, 4'b1111);
      chk("rst_mid_rgb", rgb_c, 3'b001);
      chk("rst_mid_pa", pa_c, 1'b0);
      step(1'b0, 8'h00);
      chk("rst_mid_pa_after", pa_c, 1'b0);

      step(1'b1, 8'($urandom)); chk("cyc1_rgb", rgb_y, 3'b001); chk("cyc1_r0", relay_y[0], 1'b1);
      step(1'b1, 8'($urandom)); chk("cyc2_rgb", rgb_y, 3'b010); chk("cyc2_r0", relay_y[0], 1'b0);
      step(1'b1, 8'($urandom)); chk("cyc3_rgb", rgb_y, 3'b100); chk("cyc3_r0", relay_y[0], 1'b0);
      step(1'b1, 8'($urandom)); chk("cyc4_rgb", rgb_y, 3'b001); chk("cyc4_r0", relay_y[0], 1'b1);

      for (int n = 0; n < 600; n++) begin
         kind = int'($urandom_range(0, 15));
         b = 8'($urandom_range(0, 5));
         if (kind < 4)       b = {2'b00, 1'($urandom), b[4:0]};
         else if (kind < 7)  b = {2'b01, 1'($urandom), b[4:0]};
         else if (kind < 12) b = {2'b10, 1'($urandom), b[4:0]};
         else if (kind < 14) b = {3'b110, 5'($urandom)};
         else if (kind < 15) b = {3'b111, 5'($urandom)};
         else                b = 8'($urandom);
         step($urandom_range(0, 3) != 0, b, $urandom_range(0, 149) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
